// File: rtl/neuro_pkg.sv
// Shared constants and types for the neuro job dispatcher: register map,
// dispatcher FSM states and the packed job descriptor.
package neuro_pkg;

  localparam logic [15:0] REG_BASE_DEFAULT = 16'h8000;

  localparam logic [15:0] REG_OFF_OFFSET = 16'd0;
  localparam logic [15:0] REG_OFF_IDX    = 16'd1;
  localparam logic [15:0] REG_OFF_WGT    = 16'd2;
  localparam logic [15:0] REG_OFF_NOPS   = 16'd3;
  localparam logic [15:0] REG_OFF_DEST   = 16'd4;
  localparam logic [15:0] REG_OFF_ACT    = 16'd5;

  localparam int DESC_W = 96;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_OFF    = 4'd1,
    S_WR_IDX    = 4'd2,
    S_WR_WGT    = 4'd3,
    S_WR_NOPS   = 4'd4,
    S_WR_DEST   = 4'd5,
    S_WR_ACT    = 4'd6,
    S_START     = 4'd7,
    S_WAIT_BUSY = 4'd8,
    S_WAIT_DONE = 4'd9
  } state_t;

  typedef struct packed {
    logic [15:0] offset;
    logic [15:0] index_offset;
    logic [15:0] weight_offset;
    logic [15:0] num_ops;
    logic [15:0] dest;
    logic [15:0] act_sel;
  } job_desc_t;

  function automatic job_desc_t pack_desc(
    input logic [15:0] offset,
    input logic [15:0] index_offset,
    input logic [15:0] weight_offset,
    input logic [15:0] num_ops,
    input logic [15:0] dest,
    input logic [15:0] act_sel
  );
    job_desc_t d;
    d.offset        = offset;
    d.index_offset  = index_offset;
    d.weight_offset = weight_offset;
    d.num_ops       = num_ops;
    d.dest          = dest;
    d.act_sel       = act_sel;
    return d;
  endfunction

endpackage

// File: rtl/neuro_job_fifo.sv
// Descriptor queue: synchronous FIFO, DEPTH entries (power of two, >= 2),
// first-word-fall-through read port, pushes ignored when full.
module neuro_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Full/empty come from the registered count, so a same-cycle pop never
  // makes room for a push into a full queue.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/neuro_job_dispatcher.sv
// Job dispatcher: queues neuron-engine job descriptors and replays each one as
// six register writes and a start pulse, then waits for the engine to finish.
module neuro_job_dispatcher
  import neuro_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 4,
  parameter logic [15:0] REG_BASE      = REG_BASE_DEFAULT,
  parameter int          BUSY_WAIT_MAX = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         job_valid,
  output logic                         job_ready,
  input  logic [15:0]                  job_offset,
  input  logic [15:0]                  job_index_offset,
  input  logic [15:0]                  job_weight_offset,
  input  logic [15:0]                  job_num_ops,
  input  logic [15:0]                  job_dest,
  input  logic [15:0]                  job_act_sel,
  output logic [15:0]                  Address,
  output logic [15:0]                  InputData,
  output logic                         WE,
  output logic [1:0]                   CacheSelect,
  output logic                         StartOperation,
  input  logic                         ReadyForNextOp,
  output logic                         job_done,
  output logic [15:0]                  job_done_dest,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [15:0]                  jobs_completed,
  output logic [3:0]                   dbg_state
);

  localparam int WCW = (BUSY_WAIT_MAX > 2) ? $clog2(BUSY_WAIT_MAX) : 1;

  // Handshake: a descriptor is accepted on a rising edge where job_valid and
  // job_ready are both high; job_ready depends only on registered FIFO state.
  job_desc_t  fifo_in, fifo_head;
  logic       fifo_full, fifo_empty, fifo_pop;

  state_t     state_q, state_d;
  job_desc_t  hold_q, hold_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0] addr_q, addr_d, data_q, data_d;
  logic        we_q, we_d, start_q, start_d, done_q, done_d;
  logic [15:0] done_dest_q, done_dest_d, jobs_q, jobs_d;
  logic        complete;
  logic [15:0] complete_dest;

  assign fifo_in = pack_desc(job_offset, job_index_offset, job_weight_offset,
                             job_num_ops, job_dest, job_act_sel);

  neuro_job_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DESC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (job_valid),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign job_ready      = !fifo_full;
  assign Address        = addr_q;
  assign InputData      = data_q;
  assign WE             = we_q;
  assign CacheSelect    = 2'b00;
  assign StartOperation = start_q;
  assign job_done       = done_q;
  assign job_done_dest  = done_dest_q;
  assign jobs_completed = jobs_q;
  assign busy           = (state_q != S_IDLE);
  assign dbg_state      = state_q;

  // Next-state logic. Pin outputs trail the state by one edge since they are
  // registered from state_q below.
  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    wait_cnt_d    = wait_cnt_q;
    fifo_pop      = 1'b0;
    complete      = 1'b0;
    complete_dest = hold_q.dest;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && ReadyForNextOp) begin
          fifo_pop = 1'b1;
          hold_d   = fifo_head;
          if (fifo_head.num_ops == 16'd0) begin
            complete      = 1'b1;
            complete_dest = fifo_head.dest;
          end else begin
            state_d = S_WR_OFF;
          end
        end
      end
      S_WR_OFF:  state_d = S_WR_IDX;
      S_WR_IDX:  state_d = S_WR_WGT;
      S_WR_WGT:  state_d = S_WR_NOPS;
      S_WR_NOPS: state_d = S_WR_DEST;
      S_WR_DEST: state_d = S_WR_ACT;
      S_WR_ACT:  state_d = S_START;
      S_START: begin
        state_d    = S_WAIT_BUSY;
        wait_cnt_d = '0;
      end
      S_WAIT_BUSY: begin
        // An engine that never drops ReadyForNextOp is treated as having
        // finished instantly once the wait window expires.
        if (!ReadyForNextOp) begin
          state_d = S_WAIT_DONE;
        end else if (wait_cnt_q == WCW'(BUSY_WAIT_MAX - 1)) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      S_WAIT_DONE: begin
        if (ReadyForNextOp) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered engine-side outputs.
  always_comb begin
    we_d    = 1'b0;
    addr_d  = 16'd0;
    data_d  = 16'd0;
    start_d = (state_q == S_START);
    case (state_q)
      S_WR_OFF:  begin we_d = 1'b1; addr_d = REG_BASE + REG_OFF_OFFSET; data_d = hold_q.offset;        end
      S_WR_IDX:  begin we_d = 1'b1; addr_d = REG_BASE + REG_OFF_IDX;    data_d = hold_q.index_offset;  end
      S_WR_WGT:  begin we_d = 1'b1; addr_d = REG_BASE + REG_OFF_WGT;    data_d = hold_q.weight_offset; end
      S_WR_NOPS: begin we_d = 1'b1; addr_d = REG_BASE + REG_OFF_NOPS;   data_d = hold_q.num_ops;       end
      S_WR_DEST: begin we_d = 1'b1; addr_d = REG_BASE + REG_OFF_DEST;   data_d = hold_q.dest;          end
      S_WR_ACT:  begin we_d = 1'b1; addr_d = REG_BASE + REG_OFF_ACT;    data_d = hold_q.act_sel;       end
      default: ;
    endcase
    done_d      = complete;
    done_dest_d = complete ? complete_dest : 16'd0;
    jobs_d      = complete ? (jobs_q + 16'd1) : jobs_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      we_q        <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      done_dest_q <= '0;
      jobs_q      <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      wait_cnt_q  <= wait_cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      we_q        <= we_d;
      start_q     <= start_d;
      done_q      <= done_d;
      done_dest_q <= done_dest_d;
      jobs_q      <= jobs_d;
    end
  end

endmodule

// File: doc/neuro_job_dispatcher.md
NEURO_JOB_DISPATCHER -- requirements
Module: neuro_job_dispatcher

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: number of queued job descriptors (power of two).
REQ-002 Parameter REG_BASE, default 16'h8000: address of the first control register (offset register).
REQ-003 Parameter BUSY_WAIT_MAX, default 3: number of cycles to wait for ReadyForNextOp to fall after a start.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 job_valid  in  1  descriptor present on the job_* inputs.
REQ-007 job_ready  out  1  the FIFO can accept a descriptor; equals !full.
REQ-008 job_offset, job_index_offset, job_weight_offset, job_num_ops, job_dest, job_act_sel  in  16 each  descriptor fields.
REQ-009 Address  out  16  address driven to the neuron engine.
REQ-010 InputData  out  16  write data driven to the neuron engine.
REQ-011 WE  out  1  write enable to the neuron engine.
REQ-012 CacheSelect  out  2  held at 2'b00 at all times.
REQ-013 StartOperation  out  1  single-cycle start pulse.
REQ-014 ReadyForNextOp  in  1  engine idle/finished indication.
REQ-015 job_done  out  1  one-cycle pulse when a job completes.
REQ-016 job_done_dest  out  16  job_dest of the completed job; valid while job_done is high.
REQ-017 busy  out  1  FSM is not in IDLE.
REQ-018 fifo_count  out  clog2(FIFO_DEPTH)+1  number of queued descriptors.
REQ-019 jobs_completed  out  16  count of completed jobs; wraps from 16'hFFFF to 0.

Function
REQ-020 A push shall occur when job_valid && job_ready; the full check uses the state at the start of the cycle, so a pop in the same cycle does not allow a push when full.
REQ-021 FSM states: IDLE, WR_OFF, WR_IDX, WR_WGT, WR_NOPS, WR_DEST, WR_ACT, START, WAIT_BUSY, WAIT_DONE.
REQ-022 In IDLE with the FIFO non-empty and ReadyForNextOp high, the dispatcher shall pop the head descriptor into a holding register and enter WR_OFF on the next edge.
REQ-023 WR_OFF..WR_ACT shall each last 1 cycle, with WE=1 and Address=REG_BASE+0,+1,+2,+3,+4,+5 respectively, and InputData equal to offset, index_offset, weight_offset, num_ops, dest, act_sel respectively.
REQ-024 In START: WE=0 and StartOperation=1 for exactly one cycle, then enter WAIT_BUSY.
REQ-025 WAIT_BUSY: on ReadyForNextOp=0, go to WAIT_DONE; after BUSY_WAIT_MAX cycles with ReadyForNextOp still 1, treat the job as complete.
REQ-026 WAIT_DONE: on ReadyForNextOp=1, complete the job.
REQ-027 Completion (either path): assert job_done for 1 cycle with job_done_dest set, increment jobs_completed, and return to IDLE.
REQ-028 A descriptor with job_num_ops==0 shall skip WR_*/START and complete directly from IDLE (job_done the cycle after the pop), and no engine write or start shall be issued for it.
REQ-029 Outputs shall be registered; WE, StartOperation and job_done are never high in the same cycle.
REQ-030 Outside the WR_* states, Address and InputData shall hold 0.
REQ-031 Latency: a push into an empty FIFO in IDLE gives the WR_OFF cycle 2 cycles after the accepting edge and StartOperation 8 cycles after it.

Reset
REQ-032 rst shall asynchronously clear the FIFO (fifo_count=0), put the FSM in IDLE, and zero all outputs except job_ready=1, including during a job in flight.
REQ-033 The first dispatch after reset shall begin only after rst deasserts.

Structure
REQ-034 A shared package neuro_pkg shall hold REG_BASE, the register offsets 0..5, and the FSM state enum.
REQ-035 The FIFO shall be a sub-module named neuro_job_fifo (96-bit width, FIFO_DEPTH entries, with push, pop, full, empty and count).

Verification
REQ-036 The bench shall push a descriptor {1,1,1,3,1,0} with the engine model dropping ReadyForNextOp 2 cycles after start for 20 cycles, and check writes 8000..8005 = 1,1,1,3,1,0, one StartOperation pulse, and job_done with job_done_dest=1.
REQ-037 The bench shall push 5 jobs back-to-back with FIFO_DEPTH=4, and check that job_ready drops at count 4, that no descriptor is lost, and that the done order matches the push order.
REQ-038 The bench shall push a job with num_ops=0, and check that no WE or StartOperation occurs, that job_done fires, and that jobs_completed increments by 1.
REQ-039 The bench shall hold ReadyForNextOp at 1 permanently, and check that completion occurs BUSY_WAIT_MAX cycles after WAIT_BUSY is entered.
REQ-040 The bench shall assert rst during WR_NOPS, and check that WE, StartOperation and fifo_count become 0 immediately and that the FSM is in IDLE.
REQ-041 The bench shall preload jobs_completed to 16'hFFFF by completing jobs, complete one more job, and check that it reads 0.
